// File: rtl/switch_debouncer.sv
// Per-bit two-flop synchronizer and stability-counter debouncer for slide switches.
// Produces clean levels plus registered one-cycle rise/fall strobes.
module switch_debouncer #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int               CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] db_q, db_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            db_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q   <= sw;
            s2_q   <= s1_q;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Any sample matching the current level restarts the count; terminal count always resolves.
    always_comb begin
        db_d   = db_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == TERM) begin
                    db_d[i]   = s2_q[i];
                    rise_d[i] = s2_q[i];
                    fall_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign sw_db = db_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer (WIDTH=8, STABLE_CYCLES=4) with a queue
// of expected per-cycle output snapshots popped after each clock edge.
module tb_switch_debouncer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw;
    logic [7:0] sw_db, rise, fall;

    switch_debouncer #(.WIDTH(8), .STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw),
        .sw_db (sw_db),
        .rise  (rise),
        .fall  (fall)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] db;
        logic [7:0] ri;
        logic [7:0] fa;
    } exp_t;

    exp_t sbq[$];
    int   ncmp = 0;
    int   nmis = 0;

    task automatic push(input string tag, input logic [7:0] d, input logic [7:0] r, input logic [7:0] f);
        exp_t e;
        e.tag = tag; e.db = d; e.ri = r; e.fa = f;
        sbq.push_back(e);
    endtask

    task automatic cmp1(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s.%s: observed %h expected %h", tag, fld, obs, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sbq.size() == 0) begin
            ncmp++;
            nmis++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
            return;
        end
        e = sbq.pop_front();
        cmp1(e.tag, "sw_db", sw_db, e.db);
        cmp1(e.tag, "rise",  rise,  e.ri);
        cmp1(e.tag, "fall",  fall,  e.fa);
    endtask

    // One clock: drive sw, record expectation, check just after the edge.
    task automatic cyc(input string tag, input logic [7:0] s, input logic [7:0] d,
                       input logic [7:0] r, input logic [7:0] f);
        sw = s;
        push(tag, d, r, f);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic now(input string tag, input logic [7:0] d, input logic [7:0] r, input logic [7:0] f);
        push(tag, d, r, f);
        pop_check();
    endtask

    // Hold s: five quiet edges at dold, update on the sixth, quiet on the seventh.
    task automatic settle(input string tag, input logic [7:0] s, input logic [7:0] dold,
                          input logic [7:0] dnew, input logic [7:0] r, input logic [7:0] f);
        for (int i = 0; i < 5; i++) cyc(tag, s, dold, 8'h00, 8'h00);
        cyc({tag, "_upd"}, s, dnew, r, f);
        cyc({tag, "_post"}, s, dnew, 8'h00, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish within budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic p [10];
        p = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        sw    = 8'hFF;
        #2;
        now("rst_hold0", 8'h00, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        now("rst_hold1", 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;
        settle("rst_hi", 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00);

        rst_n = 1'b0;
        sw    = 8'h00;
        #2;
        now("rst_async0", 8'h00, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        settle("toggle", 8'h01, 8'h00, 8'h01, 8'h01, 8'h00);

        for (int i = 0; i < 10; i++) cyc("bounce", {4'b0000, p[i], 3'b001}, 8'h01, 8'h00, 8'h00);
        cyc("bounce_upd", 8'h09, 8'h09, 8'h08, 8'h00);
        cyc("bounce_post", 8'h09, 8'h09, 8'h00, 8'h00);

        settle("multi", 8'h20, 8'h09, 8'h20, 8'h20, 8'h09);

        for (int i = 0; i < 3; i++) cyc("glitch3", 8'h00, 8'h20, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++) cyc("glitch3_ret", 8'h20, 8'h20, 8'h00, 8'h00);

        for (int i = 0; i < 4; i++) cyc("low4", 8'h00, 8'h20, 8'h00, 8'h00);
        cyc("low4_ret", 8'h20, 8'h20, 8'h00, 8'h00);
        cyc("low4_fall", 8'h20, 8'h00, 8'h00, 8'h20);
        for (int i = 0; i < 3; i++) cyc("low4_wait", 8'h20, 8'h00, 8'h00, 8'h00);
        cyc("low4_rise", 8'h20, 8'h20, 8'h20, 8'h00);
        cyc("low4_post", 8'h20, 8'h20, 8'h00, 8'h00);

        settle("to80", 8'h80, 8'h20, 8'h80, 8'h80, 8'h20);
        settle("simul", 8'h04, 8'h80, 8'h04, 8'h04, 8'h80);

        for (int i = 0; i < 4; i++) cyc("midcnt", 8'h06, 8'h04, 8'h00, 8'h00);
        #3;
        rst_n = 1'b0;
        #1;
        now("rst_mid_async", 8'h00, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        now("rst_mid_hold", 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;
        settle("rst_mid", 8'h06, 8'h00, 8'h06, 8'h06, 8'h00);

        ncmp++;
        assert (sbq.size() == 0) else begin
            nmis++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Per-bit synchronizer and debouncer for the board slide switches. It converts raw asynchronous `sw` inputs into clean, glitch-free levels plus one-cycle rise and fall strobes. It sits between the switch pins and the lab's combinational logic (stair light, half adder, 2-bit adder), which take `sw_db` in place of the raw switches. Each bit runs independently: synchronizer, stability counter, and registered output.

## Interface

- `WIDTH`, 8: number of switch bits handled.
- `STABLE_CYCLES`, 1000000: consecutive clock edges a synchronized input must differ from `sw_db` before `sw_db` updates. At 100 MHz the default is 10 ms. Legal range is 2 to 2^24.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronous to `clk`.
- `sw` input WIDTH: raw switch levels, asynchronous to `clk`.
- `sw_db` output WIDTH: debounced switch levels.
- `rise` output WIDTH: one-cycle strobe per bit when `sw_db[i]` goes 0→1.
- `fall` output WIDTH: one-cycle strobe per bit when `sw_db[i]` goes 1→0.

## Operation

- Per bit, a two-flop synchronizer: `s1[i] <= sw[i]`, then `s2[i] <= s1[i]`. Only `s2` feeds the logic below.
- Per bit, a stability counter `cnt[i]` of width `$clog2(STABLE_CYCLES)`, unsigned.
- At each rising edge, for each bit:
  - **`s2[i] == sw_db[i]`**: set `cnt[i] <= 0`. `sw_db[i]` holds.
  - **`s2[i] != sw_db[i]` and `cnt[i] < STABLE_CYCLES-1`**: set `cnt[i] <= cnt[i]+1`.
  - **`s2[i] != sw_db[i]` and `cnt[i] == STABLE_CYCLES-1`**: set `sw_db[i] <= s2[i]` and `cnt[i] <= 0`. Assert `rise[i]` if `s2[i]` is 1, otherwise assert `fall[i]`.
- `rise` and `fall` are registered. They default to 0 every cycle and are high for exactly one cycle per update. `rise[i]` and `fall[i]` are never high together.
- Any return of `s2[i]` to `sw_db[i]`, even for a single edge, restarts the count from 0. Bounces shorter than `STABLE_CYCLES` therefore never reach the outputs.
- Bits are fully independent. Several bits may update, and strobe, on the same edge.
- The counter never wraps: the terminal count always resolves to either an update or a clear.
- On reset assertion, immediately and asynchronously:
  - `s1`, `s2`, `sw_db`, `rise`, `fall` are all 0.
  - All `cnt` are 0.
  - Any in-progress count is discarded.
- After reset, switches that are already high are reported through the normal debounce path, ending in a `rise` strobe.

## Timing

- Reset values: `sw_db`=0, `rise`=0, `fall`=0.
- Latency: `sw[i]` changes and is held stable. Call the first rising edge that samples the new value into `s1` edge 1. `sw_db[i]` and its strobe update at edge `STABLE_CYCLES+2`.
- With `STABLE_CYCLES`=4, that is the 6th edge after the change.
- A strobe is visible for the cycle following its update edge only.
- Worst-case minimum pulse filtered: any input level held fewer than `STABLE_CYCLES` edges at `s2` produces no output change.
- No combinational path from `sw` to any output.

## Test plan

All scenarios use `WIDTH`=8 and `STABLE_CYCLES`=4.

- **Reset with switches high**: hold `rst_n`=0 with `sw`=8'hFF.
  - During reset, `sw_db`=0 and `rise`=`fall`=0.
  - Release reset, then count edges; at the 6th edge after release, `sw_db`=8'hFF.
  - `rise`=8'hFF for exactly one cycle, then 0.
- **Clean toggle**: `sw[0]` 0→1, held.
  - `sw_db[0]` goes high on the 6th edge.
  - `rise`=8'h01 for one cycle; `fall` stays 0 throughout.
- **Bounce**: `sw[3]` follows the pattern 1,0,1,1,0,1,1,1,1,1 (one value per cycle).
  - No output change until 4 consecutive stable samples reach `s2`.
  - `sw_db[3]` then rises exactly once, with one `rise`=8'h08 strobe.
- **Glitch rejection**: with `sw_db`=8'h20, drive `sw[5]` low for 3 cycles and then back high.
  - `sw_db` stays 8'h20 throughout.
  - `rise` and `fall` stay 0 throughout.
- **Simultaneous bits**: from `sw_db`=8'h80, set `sw[2]`=1 and `sw[7]`=0 on the same cycle.
  - Both bits update on the same edge, giving `sw_db`=8'h04.
  - On that cycle, `rise`=8'h04 and `fall`=8'h80.
- **Reset mid-count**: assert `rst_n`=0 asynchronously 2 edges into a count on `sw[1]`.
  - Outputs go 0 immediately, without waiting for a clock edge.
  - After release, the full 6-edge latency applies again before `sw_db[1]` rises.
